// File: rtl/alu_logic_pkg.sv
// Shared opcode encoding and status-flag layout for the pipelined bitwise logic unit.
package alu_logic_pkg;

    localparam int FLAG_W    = 4;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_ONES = 1;
    localparam int FLAG_PAR  = 2;
    localparam int FLAG_EQ   = 3;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise function and flag generation; sits between the S1 and S2 registers.
module alu_logic_core
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [2:0]        i_op,
    output logic [WIDTH-1:0]  o_result,
    output logic [FLAG_W-1:0] o_flags
);

    always_comb begin
        o_result = '0;
        case (op_e'(i_op))
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_XNOR:  o_result = ~(i_a ^ i_b);
            OP_NAND:  o_result = ~(i_a & i_b);
            OP_NOR:   o_result = ~(i_a | i_b);
            OP_NOTA:  o_result = ~i_a;
            OP_PASSA: o_result = i_a;
            default:  o_result = i_a;
        endcase
    end

    // EQ looks at the operands, not the result, so it is opcode independent.
    always_comb begin
        o_flags            = '0;
        o_flags[FLAG_Z]    = (o_result == '0);
        o_flags[FLAG_ONES] = &o_result;
        o_flags[FLAG_PAR]  = ^o_result;
        o_flags[FLAG_EQ]   = (i_a == i_b);
    end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 holds operands, S2 holds result and flags.
module alu_logic_pipe #(
    parameter int WIDTH  = 16,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [FLAG_W-1:0] out_flags
);
    import alu_logic_pkg::*;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_op;
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_data;
    logic [FLAG_W-1:0] r_flags;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_accept;
    logic [WIDTH-1:0]  w_result;
    logic [FLAG_W-1:0] w_flags;

    // A stage may load when it is empty or its contents leave this edge.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv && !rst;
    assign w_accept = in_valid && in_ready;

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_data     <= '0;
            r_flags    <= '0;
        end else begin
            if (w_s1_adv)
                r_s1_valid <= w_accept;
            if (w_accept) begin
                r_a  <= in_a;
                r_b  <= in_b;
                r_op <= in_op;
            end
            // S2 data only changes when a new result replaces it, keeping outputs stable otherwise.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_data  <= w_result;
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_data;
    assign out_flags = r_flags;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Bench for alu_logic_pipe: directed vector table, backpressure/reset sequences and a
// random scoreboard run across WIDTH=16, 1 and 64 instances sharing one stimulus.
module tb_alu_logic_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [2:0]  in_op;

    logic        rdy16, ov16, rdy1, ov1, rdy64, ov64;
    logic [15:0] d16;
    logic [0:0]  d1;
    logic [63:0] d64;
    logic [3:0]  f16, f1, f64;

    int total = 0;
    int bad   = 0;

    alu_logic_pipe #(.WIDTH(16), .FLAG_W(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_op(in_op),
        .out_valid(ov16), .out_ready(out_ready), .out_data(d16), .out_flags(f16));

    alu_logic_pipe #(.WIDTH(1), .FLAG_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op),
        .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_flags(f1));

    alu_logic_pipe #(.WIDTH(64), .FLAG_W(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(ov64), .out_ready(out_ready), .out_data(d64), .out_flags(f64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rdy, ov;
    logic [63:0] od [3];
    logic [3:0]  of [3];
    assign rdy   = {rdy64, rdy1, rdy16};
    assign ov    = {ov64, ov1, ov16};
    assign od[0] = {48'b0, d16};
    assign od[1] = {63'b0, d1};
    assign od[2] = d64;
    assign of[0] = f16;
    assign of[1] = f1;
    assign of[2] = f64;

    // Expected {flags, data}: flags = {EQ, PAR, ONES, Z} over the low w bits.
    function automatic logic [67:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] op, input int w);
        logic [63:0] m, aa, bb, r;
        m  = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        aa = a & m;
        bb = b & m;
        case (op)
            3'd0:    r = aa & bb;
            3'd1:    r = aa | bb;
            3'd2:    r = aa ^ bb;
            3'd3:    r = ~(aa ^ bb);
            3'd4:    r = ~(aa & bb);
            3'd5:    r = ~(aa | bb);
            3'd6:    r = ~aa;
            default: r = aa;
        endcase
        r = r & m;
        return {(aa == bb), ^r, (r == m), (r == 64'd0), r};
    endfunction

    function automatic int wid(input int k);
        return (k == 0) ? 16 : (k == 1) ? 1 : 64;
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    logic [67:0] sq0 [$];
    logic [67:0] sq1 [$];
    logic [67:0] sq2 [$];
    logic [67:0] hold_v [3];
    bit   [2:0]  hold_on = '0;

    // Called once per negedge: sees exactly what the next rising edge will sample.
    task automatic mon();
        logic [67:0] got, e;
        bit emp;
        if (rst) begin
            sq0.delete(); sq1.delete(); sq2.delete();
            hold_on = '0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            got = {of[k], od[k]};
            if (hold_on[k]) begin
                chk("hold_valid", {67'b0, ov[k]}, 68'd1);
                chk("hold_data", got, hold_v[k]);
            end
            hold_on[k] = ov[k] && !out_ready;
            hold_v[k]  = got;
            if (ov[k] && out_ready) begin
                emp = 1'b0;
                e   = '0;
                case (k)
                    0: if (sq0.size() == 0) emp = 1'b1; else e = sq0.pop_front();
                    1: if (sq1.size() == 0) emp = 1'b1; else e = sq1.pop_front();
                    default: if (sq2.size() == 0) emp = 1'b1; else e = sq2.pop_front();
                endcase
                if (emp) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected inst=%0d got=%0h exp=none", k, got);
                end else begin
                    chk("sb_result", got, e);
                end
            end
            if (in_valid && rdy[k]) begin
                e = ref_model(in_a, in_b, in_op, wid(k));
                case (k)
                    0: sq0.push_back(e);
                    1: sq1.push_back(e);
                    default: sq2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        mon();
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] d;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];
    int   acc;
    logic [15:0] held;

    initial begin
        tbl[0]  = '{16'hF0F0, 16'hFF00, 3'd3, 16'hF00F, 4'b0000};
        tbl[1]  = '{16'h00FF, 16'h0FF0, 3'd0, 16'h00F0, 4'b0000};
        tbl[2]  = '{16'h00FF, 16'h0FF0, 3'd1, 16'h0FFF, 4'b0000};
        tbl[3]  = '{16'h00FF, 16'h0FF0, 3'd2, 16'h0F0F, 4'b0000};
        tbl[4]  = '{16'h00FF, 16'h0FF0, 3'd3, 16'hF0F0, 4'b0000};
        tbl[5]  = '{16'h00FF, 16'h0FF0, 3'd4, 16'hFF0F, 4'b0000};
        tbl[6]  = '{16'h00FF, 16'h0FF0, 3'd5, 16'hF000, 4'b0000};
        tbl[7]  = '{16'h00FF, 16'h0FF0, 3'd6, 16'hFF00, 4'b0000};
        tbl[8]  = '{16'h00FF, 16'h0FF0, 3'd7, 16'h00FF, 4'b0000};
        tbl[9]  = '{16'h1234, 16'h1234, 3'd2, 16'h0000, 4'b1001};
        tbl[10] = '{16'hFFFF, 16'h0000, 3'd1, 16'hFFFF, 4'b0010};
        tbl[11] = '{16'h0007, 16'h0007, 3'd0, 16'h0007, 4'b1100};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;

        // Reset state
        nxt(); smp();
        chk("rst_in_ready", {65'b0, rdy}, 68'd0);
        chk("rst_out_valid", {65'b0, ov}, 68'd0);
        chk("rst_out_data", {f16, 48'b0, d16}, 68'd0);
        nxt(); rst = 1'b0; smp();
        chk("post_rst_in_ready", {65'b0, rdy}, 68'd7);

        // Directed table streamed back to back; each result due two edges after accept
        for (int k = 0; k < NV + 2; k++) begin
            nxt();
            out_ready = 1'b1;
            if (k < NV) begin
                in_valid = 1'b1;
                in_a = {48'b0, tbl[k].a}; in_b = {48'b0, tbl[k].b}; in_op = tbl[k].op;
            end else begin
                in_valid = 1'b0;
            end
            smp();
            if (k < NV) chk("tbl_in_ready", {67'b0, rdy16}, 68'd1);
            if (k >= 2) begin
                chk("tbl_valid", {67'b0, ov16}, 68'd1);
                chk("tbl_data", {52'b0, d16}, {52'b0, tbl[k-2].d});
                chk("tbl_flags", {64'b0, f16}, {64'b0, tbl[k-2].f});
            end
        end

        // Backpressure: out_ready low with continuous input offers
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            nxt();
            in_valid = 1'b1; out_ready = 1'b0; in_op = 3'd7;
            in_a = {48'b0, 16'h0101 * 16'(c + 1)}; in_b = '0;
            smp();
            if (rdy16) acc++;
            if (c >= 2) begin
                chk("bp_valid", {67'b0, ov16}, 68'd1);
                chk("bp_held", {52'b0, d16}, 68'h0101);
            end
        end
        chk("bp_accepts", 68'(acc), 68'd2);
        chk("bp_in_ready", {67'b0, rdy16}, 68'd0);
        nxt(); in_valid = 1'b0; out_ready = 1'b1; smp();
        chk("bp_drain0", {ov16, 51'b0, d16}, {1'b1, 51'b0, 16'h0101});
        nxt(); smp();
        chk("bp_drain1", {ov16, 51'b0, d16}, {1'b1, 51'b0, 16'h0202});
        nxt(); smp();
        chk("bp_empty", {67'b0, ov16}, 68'd0);

        // Reset with two transactions in flight
        nxt(); in_valid = 1'b1; out_ready = 1'b0; in_a = 64'h5A5A; in_b = 64'h1; in_op = 3'd2; smp();
        nxt(); in_a = 64'hA5A5; smp();
        held = d16;
        nxt(); in_valid = 1'b0; rst = 1'b1; smp();
        chk("midrst_in_ready", {65'b0, rdy}, 68'd0);
        chk("midrst_full", {67'b0, ov16}, 68'd1);
        nxt(); rst = 1'b0; out_ready = 1'b1; smp();
        chk("midrst_out_valid", {65'b0, ov}, 68'd0);
        chk("midrst_in_ready_after", {65'b0, rdy}, 68'd7);
        for (int c = 0; c < 4; c++) begin
            nxt(); smp();
            chk("midrst_no_emit", {65'b0, ov}, 68'd0);
        end

        // Random traffic: phase 1 mixed, 2 saturated (retire+shift+accept each edge), 3 mixed
        for (int c = 0; c < 600; c++) begin
            nxt();
            in_a = {$urandom, $urandom};
            in_b = ($urandom_range(0, 7) == 0) ? in_a : {$urandom, $urandom};
            in_op = 3'($urandom_range(0, 7));
            if (c >= 250 && c < 350) begin
                in_valid = 1'b1; out_ready = 1'b1;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end
            smp();
        end
        nxt(); in_valid = 1'b0; out_ready = 1'b1; smp();
        for (int c = 0; c < 4; c++) begin
            nxt(); smp();
        end
        chk("sb_drained", 68'(sq0.size() + sq1.size() + sq2.size()), 68'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
